cp0_ctrl: RTL and testbench

Parametrised coprocessor-0 controller for the MIPS pipeline: holds the architectural CP0 registers, runs the Count/Compare timer with a configurable prescaler, merges hardware, timer and software interrupts into one masked request, and commits exceptions and `eret` precisely. It sits beside the memory/writeback boundary. It takes one committed event per cycle from the exception stage and returns a flush plus redirect PC to the fetch stage.

---
 rtl/cp0_pkg.sv | 48 ++++
 rtl/cp0_timer.sv | 60 ++++++
 rtl/cp0_ctrl.sv | 150 +++++++++++++++
 tb/tb_cp0_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, ExcCodes, field positions,
// write masks and reset values.
package cp0_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;
  localparam logic [4:0] REG_CONFIG   = 5'd16;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12,
    EXC_TR   = 5'd13
  } exc_code_e;

  // Status field positions
  localparam int unsigned ST_IE    = 0;
  localparam int unsigned ST_EXL   = 1;
  localparam int unsigned ST_IM_LO = 8;
  localparam int unsigned ST_BEV   = 22;

  // Cause field positions
  localparam int unsigned CA_EXC_LO  = 2;
  localparam int unsigned CA_IP_LO   = 8;
  localparam int unsigned CA_IPHW_LO = 10;
  localparam int unsigned CA_BD      = 31;

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  localparam logic [31:0] STATUS_RST = 32'h0040_0000;
  localparam logic [31:0] CONFIG_RST = 32'h0000_8000;

  // Address-error exceptions are the only ones that record BadVAddr
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: prescaler, free-running Count, Compare and the
// sticky timer interrupt flag.
module cp0_timer
  import cp0_pkg::*;
#(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_irq
);

  localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

  logic [PW-1:0] r_presc;
  logic [31:0]   r_count;
  logic [31:0]   r_compare;
  logic          r_irq;
  logic          w_wrap;

  assign w_wrap = (r_presc == PRESC_MAX);

  // Prescaler and Count; a Count write restarts the prescale period
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
      r_count <= '0;
    end else if (count_we) begin
      r_presc <= '0;
      r_count <= wdata;
    end else begin
      r_presc <= w_wrap ? '0 : r_presc + 1'b1;
      if (w_wrap) r_count <= r_count + 32'd1;
    end
  end

  // Compare register and sticky match flag; a Compare write beats a match
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_compare <= '0;
      r_irq     <= 1'b0;
    end else if (compare_we) begin
      r_compare <= wdata;
      r_irq     <= 1'b0;
    end else if (r_count == r_compare) begin
      r_irq     <= 1'b1;
    end
  end

  assign count     = r_count;
  assign compare   = r_compare;
  assign timer_irq = r_irq;

endmodule

// File: rtl/cp0_ctrl.sv
// Coprocessor-0 controller: architectural CP0 registers, interrupt merge,
// precise exception / eret commit and redirect.
module cp0_ctrl
  import cp0_pkg::*;
#(
  parameter int unsigned HW_INT_N   = 6,
  parameter int unsigned TIMER_LINE = 5,
  parameter int unsigned COUNT_DIV  = 2,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [31:0] PRID_VAL   = 32'h004C_0102
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [4:0]          waddr,
  input  logic [31:0]         wdata,
  input  logic [4:0]          raddr,
  output logic [31:0]         rdata,
  input  logic [HW_INT_N-1:0] int_i,
  input  logic                exc_valid,
  input  logic [4:0]          exc_code,
  input  logic [31:0]         exc_pc,
  input  logic                exc_bd,
  input  logic [31:0]         exc_badvaddr,
  input  logic                eret,
  output logic                int_req,
  output logic                flush,
  output logic [31:0]         new_pc,
  output logic [31:0]         status,
  output logic [31:0]         cause,
  output logic [31:0]         epc,
  output logic [31:0]         count
);

  logic [7:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip_hw;
  logic [1:0]  r_ip_sw;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;
  logic [31:0] r_config;
  logic        r_int_req;

  logic        w_mtc0;
  logic        w_count_we;
  logic        w_compare_we;
  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_timer_irq;
  logic [5:0]  w_hw_lines;
  logic [31:0] w_status;
  logic [31:0] w_cause;

  // mtc0 is dropped whenever an exception or eret commits in the same cycle
  assign w_mtc0       = we & ~exc_valid & ~eret;
  assign w_count_we   = w_mtc0 & (waddr == REG_COUNT);
  assign w_compare_we = w_mtc0 & (waddr == REG_COMPARE);

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (w_count_we),
    .compare_we (w_compare_we),
    .wdata      (wdata),
    .count      (w_count),
    .compare    (w_compare),
    .timer_irq  (w_timer_irq)
  );

  // Hardware interrupt lines with the timer flag merged onto its line
  always_comb begin
    w_hw_lines                 = '0;
    w_hw_lines[HW_INT_N-1:0]   = int_i;
    w_hw_lines[TIMER_LINE]     = w_hw_lines[TIMER_LINE] | w_timer_irq;
  end

  assign w_status = {9'b0, 1'b1, 6'b0, r_im, 6'b0, r_exl, r_ie};
  assign w_cause  = {r_bd, 15'b0, r_ip_hw, r_ip_sw, 1'b0, r_exccode, 2'b0};

  // Register commit: exception beats eret beats mtc0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_im       <= '0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_ip_hw    <= '0;
      r_ip_sw    <= '0;
      r_exccode  <= '0;
      r_epc      <= '0;
      r_badvaddr <= '0;
      r_config   <= CONFIG_RST;
      r_int_req  <= 1'b0;
    end else begin
      r_ip_hw   <= w_hw_lines;
      r_int_req <= r_ie & ~r_exl & (|({r_ip_hw, r_ip_sw} & r_im));
      if (exc_valid) begin
        if (!r_exl) begin
          r_epc <= exc_bd ? exc_pc - 32'd4 : exc_pc;
          r_bd  <= exc_bd;
        end
        r_exl     <= 1'b1;
        r_exccode <= exc_code;
        if (is_addr_exc(exc_code)) r_badvaddr <= exc_badvaddr;
      end else if (eret) begin
        r_exl <= 1'b0;
      end else if (we) begin
        case (waddr)
          REG_STATUS: begin
            r_im  <= wdata[ST_IM_LO +: 8];
            r_exl <= wdata[ST_EXL];
            r_ie  <= wdata[ST_IE];
          end
          REG_CAUSE:  r_ip_sw  <= wdata[CA_IP_LO +: 2];
          REG_EPC:    r_epc    <= wdata;
          REG_CONFIG: r_config <= wdata;
          default: ;
        endcase
      end
    end
  end

  // mfc0 read mux, pre-edge state
  always_comb begin
    rdata = '0;
    case (raddr)
      REG_BADVADDR: rdata = r_badvaddr;
      REG_COUNT:    rdata = w_count;
      REG_COMPARE:  rdata = w_compare;
      REG_STATUS:   rdata = w_status;
      REG_CAUSE:    rdata = w_cause;
      REG_EPC:      rdata = r_epc;
      REG_PRID:     rdata = PRID_VAL;
      REG_CONFIG:   rdata = r_config;
      default:      rdata = '0;
    endcase
  end

  assign flush   = exc_valid | eret;
  assign new_pc  = exc_valid ? EXC_VECTOR : r_epc;
  assign int_req = r_int_req;
  assign status  = w_status;
  assign cause   = w_cause;
  assign epc     = r_epc;
  assign count   = w_count;

endmodule

// File: tb/tb_cp0_ctrl.sv
// Scoreboard bench for cp0_ctrl: the driver predicts each cycle's visible
// outputs from a behavioural model and queues them; the monitor compares.
module tb_cp0_ctrl;

  localparam int unsigned HW_N  = 6;
  localparam int unsigned TLINE = 5;
  localparam int unsigned DIV   = 2;
  localparam logic [31:0] VEC   = 32'hBFC0_0380;
  localparam logic [31:0] PRID  = 32'h004C_0102;

  logic            clk;
  logic            rst;
  logic            we;
  logic [4:0]      waddr;
  logic [31:0]     wdata;
  logic [4:0]      raddr;
  logic [31:0]     rdata;
  logic [HW_N-1:0] int_i;
  logic            exc_valid;
  logic [4:0]      exc_code;
  logic [31:0]     exc_pc;
  logic            exc_bd;
  logic [31:0]     exc_badvaddr;
  logic            eret;
  logic            int_req;
  logic            flush;
  logic [31:0]     new_pc;
  logic [31:0]     status;
  logic [31:0]     cause;
  logic [31:0]     epc;
  logic [31:0]     count;

  cp0_ctrl #(
    .HW_INT_N   (HW_N),
    .TIMER_LINE (TLINE),
    .COUNT_DIV  (DIV),
    .EXC_VECTOR (VEC),
    .PRID_VAL   (PRID)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .we           (we),
    .waddr        (waddr),
    .wdata        (wdata),
    .raddr        (raddr),
    .rdata        (rdata),
    .int_i        (int_i),
    .exc_valid    (exc_valid),
    .exc_code     (exc_code),
    .exc_pc       (exc_pc),
    .exc_bd       (exc_bd),
    .exc_badvaddr (exc_badvaddr),
    .eret         (eret),
    .int_req      (int_req),
    .flush        (flush),
    .new_pc       (new_pc),
    .status       (status),
    .cause        (cause),
    .epc          (epc),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] new_pc;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] count;
    logic        flush;
    logic        int_req;
  } exp_t;

  exp_t q[$];
  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  // Behavioural model state
  logic [7:0]  m_im;
  logic        m_exl, m_ie, m_bd;
  logic [5:0]  m_ip_hw;
  logic [1:0]  m_ip_sw;
  logic [4:0]  m_exc;
  logic [31:0] m_epc, m_badv, m_cfg, m_cmp;
  logic [31:0] m_base;      // Count value at last load
  int unsigned m_since;     // clock edges since last load
  logic        m_flag, m_intreq;

  function automatic logic [31:0] m_count();
    return m_base + 32'(m_since / DIV);
  endfunction

  function automatic logic [31:0] m_status();
    return 32'h0040_0000 | ({24'b0, m_im} << 8) | ({31'b0, m_exl} << 1) | {31'b0, m_ie};
  endfunction

  function automatic logic [31:0] m_cause();
    return ({31'b0, m_bd} << 31) | ({26'b0, m_ip_hw} << 10) | ({30'b0, m_ip_sw} << 8)
           | ({27'b0, m_exc} << 2);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_badv;
      5'd9:    return m_count();
      5'd11:   return m_cmp;
      5'd12:   return m_status();
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      5'd15:   return PRID;
      5'd16:   return m_cfg;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_im = '0; m_exl = 0; m_ie = 0; m_bd = 0; m_ip_hw = '0; m_ip_sw = '0;
    m_exc = '0; m_epc = '0; m_badv = '0; m_cfg = 32'h0000_8000; m_cmp = '0;
    m_base = '0; m_since = 0; m_flag = 0; m_intreq = 0;
  endtask

  // Predict this cycle's outputs, queue them, then advance the model
  // across the coming rising edge.
  task automatic step();
    exp_t        e;
    logic [31:0] cnt;
    logic [5:0]  lines;
    logic        mtc0, nreq;
    if (!rst) model_reset();
    e.rdata   = m_read(raddr);
    e.status  = m_status();
    e.cause   = m_cause();
    e.epc     = m_epc;
    e.count   = m_count();
    e.int_req = m_intreq;
    e.flush   = exc_valid | eret;
    e.new_pc  = exc_valid ? VEC : m_epc;
    q.push_back(e);
    if (!rst) return;

    cnt   = m_count();
    nreq  = m_ie & ~m_exl & (|({m_ip_hw, m_ip_sw} & m_im));
    lines = int_i;
    if (m_flag) lines[TLINE] = 1'b1;
    mtc0  = we & ~exc_valid & ~eret;

    if (mtc0 && waddr == 5'd11) begin
      m_cmp = wdata; m_flag = 0;
    end else if (cnt == m_cmp) begin
      m_flag = 1;
    end
    if (mtc0 && waddr == 5'd9) begin
      m_base = wdata; m_since = 0;
    end else begin
      m_since++;
    end

    if (exc_valid) begin
      if (!m_exl) begin
        m_epc = exc_bd ? exc_pc - 32'd4 : exc_pc;
        m_bd  = exc_bd;
      end
      m_exl = 1;
      m_exc = exc_code;
      if (exc_code == 5'd4 || exc_code == 5'd5) m_badv = exc_badvaddr;
    end else if (eret) begin
      m_exl = 0;
    end else if (mtc0) begin
      case (waddr)
        5'd12: begin m_im = wdata[15:8]; m_exl = wdata[1]; m_ie = wdata[0]; end
        5'd13: m_ip_sw = wdata[9:8];
        5'd14: m_epc = wdata;
        5'd16: m_cfg = wdata;
        default: ;
      endcase
    end
    m_ip_hw  = lines;
    m_intreq = nreq;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare every queued prediction once outputs have settled
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      while (q.size() > 0) begin
        e = q.pop_front();
        chk("rdata",   rdata,   e.rdata);
        chk("status",  status,  e.status);
        chk("cause",   cause,   e.cause);
        chk("epc",     epc,     e.epc);
        chk("count",   count,   e.count);
        chk("int_req", {31'b0, int_req}, {31'b0, e.int_req});
        chk("flush",   {31'b0, flush},   {31'b0, e.flush});
        if (e.flush) chk("new_pc", new_pc, e.new_pc);
      end
    end
  end

  task automatic idle();
    we = 0; exc_valid = 0; eret = 0;
  endtask

  task automatic tick();
    step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    idle(); we = 1; waddr = a; wdata = d;
    tick();
    idle();
  endtask

  task automatic exc(input logic [4:0] c, input logic [31:0] pc, input logic bd,
                     input logic [31:0] bv);
    idle(); exc_valid = 1; exc_code = c; exc_pc = pc; exc_bd = bd; exc_badvaddr = bv;
    tick();
    idle();
  endtask

  function automatic logic [4:0] rnd_reg();
    case ($urandom_range(0, 9))
      0: return 5'd8;   1: return 5'd9;   2: return 5'd11;  3: return 5'd12;
      4: return 5'd13;  5: return 5'd14;  6: return 5'd15;  7: return 5'd16;
      8: return 5'd3;   default: return 5'd20;
    endcase
  endfunction

  function automatic logic [4:0] rnd_wreg();
    case ($urandom_range(0, 6))
      0: return 5'd9;   1: return 5'd11;  2: return 5'd12;  3: return 5'd13;
      4: return 5'd14;  5: return 5'd3;   default: return 5'd21;
    endcase
  endfunction

  function automatic logic [4:0] rnd_code();
    case ($urandom_range(0, 7))
      0: return 5'd0;  1: return 5'd4;  2: return 5'd5;  3: return 5'd8;
      4: return 5'd9;  5: return 5'd10; 6: return 5'd12; default: return 5'd13;
    endcase
  endfunction

  initial begin : driver
    int unsigned r;
    rst = 0; idle(); waddr = '0; wdata = '0; raddr = 5'd12; int_i = '0;
    exc_code = '0; exc_pc = '0; exc_bd = 0; exc_badvaddr = '0;
    @(negedge clk);
    tick(); tick();
    rst = 1;

    // Timer: Compare=5, watch Count and Cause
    raddr = 5'd13;
    wr(5'd11, 32'd5);
    repeat (14) tick();
    // Interrupt enable, then clear the timer with a Compare write
    raddr = 5'd12;
    wr(5'd12, 32'h0000_8001);
    repeat (4) tick();
    wr(5'd11, 32'h0000_1000);
    repeat (4) tick();

    // Address error in a delay slot
    raddr = 5'd8;
    exc(5'd4, 32'hBFC0_0100, 1'b1, 32'h0000_1235);
    tick();
    // Nested exception, then eret
    raddr = 5'd13;
    exc(5'd8, 32'h0000_0400, 1'b0, 32'hDEAD_BEEF);
    tick();
    eret = 1; tick(); idle(); tick();

    // Same-cycle exception + eret + mtc0 Status=0
    wr(5'd12, 32'h0000_8001);
    exc_valid = 1; exc_code = 5'd10; exc_pc = 32'h0000_0800; exc_bd = 0;
    eret = 1; we = 1; waddr = 5'd12; wdata = 32'h0;
    raddr = 5'd12;
    tick(); idle(); tick();

    // Software interrupts via Cause, enabled by IM[0]
    raddr = 5'd13;
    int_i = 6'b000101;
    wr(5'd13, 32'hFFFF_FFFF);
    wr(5'd12, 32'h0000_0101);
    repeat (3) tick();

    // Count wrap and unimplemented register write
    raddr = 5'd9;
    wr(5'd9, 32'hFFFF_FFFE);
    wr(5'd20, 32'h1234_5678);
    repeat (6) tick();

    // Randomised traffic with a mid-run reset
    for (int i = 0; i < 600; i++) begin
      idle();
      raddr = rnd_reg();
      if ($urandom_range(0, 3) == 0) int_i = HW_N'($urandom_range(0, 63));
      rst = !(i >= 300 && i < 302);
      r = $urandom_range(0, 15);
      if (r == 0) begin
        exc_valid = 1; exc_code = rnd_code(); exc_pc = $urandom; exc_bd = $urandom_range(0, 1);
        exc_badvaddr = $urandom;
        eret = ($urandom_range(0, 3) == 0);
        we   = ($urandom_range(0, 1) == 0);
        waddr = rnd_wreg(); wdata = $urandom;
      end else if (r == 1) begin
        eret = 1;
        we = ($urandom_range(0, 1) == 0); waddr = rnd_wreg(); wdata = $urandom;
      end else if (r < 7) begin
        we = 1; waddr = rnd_wreg(); wdata = $urandom;
        if (waddr == 5'd11 && $urandom_range(0, 1) == 0)
          wdata = m_count() + 32'($urandom_range(0, 4));
        if (waddr == 5'd9 && $urandom_range(0, 2) == 0)
          wdata = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      end
      tick();
    end
    rst = 1; idle();
    repeat (3) @(negedge clk);
    #4;
    chk("drain", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
